dam_result_collector: RTL and testbench

Downstream sink for the DiffAddMult `top` datapath. It captures every result byte presented on `vo` while `out_valid` is high and buffers it in a small FIFO. The buffered results drain to a consumer over a valid/ready handshake. The block also keeps result statistics for the bench and for the chip-level checker. `top` cannot be back-pressured, so the collector never stalls the producer: results that arrive while the FIFO is full are dropped, and the drop is flagged.

---
 rtl/dam_result_collector.sv | 92 +++++++++
 tb/tb_dam_result_collector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dam_result_collector.sv
// rtl/dam_result_collector.sv - result sink FIFO with drop-on-full and result statistics
module dam_result_collector #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    res_data,
    input  logic          res_valid,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    output logic [15:0]   acc_cnt,
    output logic [7:0]    checksum,
    input  logic          clr_stats
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          push;
    logic          pop;
    logic          drop;

    // The producer cannot stall, so a full FIFO only accepts when a pop frees a slot this cycle.
    always_comb begin
        pop  = m_valid & m_ready;
        push = res_valid & ((level != LEVEL_FULL) | pop);
        drop = res_valid & ~push;
    end

    assign m_valid = (level != '0);
    assign m_data  = m_valid ? mem[rp] : 8'h00;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= res_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Clear wins over any count in the same cycle; the FIFO write itself is unaffected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
            acc_cnt  <= 16'h0000;
            checksum <= 8'h00;
        end else if (clr_stats) begin
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
            acc_cnt  <= 16'h0000;
            checksum <= 8'h00;
        end else begin
            if (push) begin
                acc_cnt  <= acc_cnt + 16'h0001;
                checksum <= checksum + res_data;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'h01;
                end
            end
        end
    end

endmodule

// File: tb/tb_dam_result_collector.sv
// tb/tb_dam_result_collector.sv - scoreboard bench for dam_result_collector
module tb_dam_result_collector;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  res_data = 8'h00;
    logic        res_valid = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [AW:0] level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [15:0] acc_cnt;
    logic [7:0]  checksum;
    logic        clr_stats = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] expQ [$];
    int         expAcc = 0;
    int         expSum = 0;
    int         expDrop = 0;
    int         expOvf = 0;

    dam_result_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .res_data(res_data), .res_valid(res_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt), .acc_cnt(acc_cnt),
        .checksum(checksum), .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compares current outputs, then applies the events of the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            expQ.delete();
            expAcc = 0; expSum = 0; expDrop = 0; expOvf = 0;
        end else begin
            checkVal("level", 32'(level), 32'(expQ.size()));
            checkVal("m_valid", 32'(m_valid), 32'(expQ.size() != 0));
            checkVal("m_data", 32'(m_data), (expQ.size() != 0) ? 32'(expQ[0]) : 32'h0);
            checkVal("acc_cnt", 32'(acc_cnt), 32'(expAcc));
            checkVal("checksum", 32'(checksum), 32'(expSum));
            checkVal("drop_cnt", 32'(drop_cnt), 32'(expDrop));
            checkVal("overflow", 32'(overflow), 32'(expOvf));
            if (m_ready && expQ.size() != 0) begin
                void'(expQ.pop_front());
            end
            if (res_valid) begin
                if (expQ.size() < DEPTH) begin
                    expQ.push_back(res_data);
                    expAcc = (expAcc + 1) % 65536;
                    expSum = (expSum + int'(res_data)) % 256;
                end else begin
                    expOvf = 1;
                    if (expDrop < 255) expDrop++;
                end
            end
            if (clr_stats) begin
                expAcc = 0; expSum = 0; expDrop = 0; expOvf = 0;
            end
        end
    end

    task automatic pushByte(input logic [7:0] d);
        res_valid = 1'b1;
        res_data  = d;
        tick();
        res_valid = 1'b0;
        res_data  = 8'h00;
    endtask

    task automatic drainAll();
        int budget;
        m_ready = 1'b1;
        budget = 0;
        while (m_valid && budget < 50) begin
            tick();
            budget++;
        end
        checkVal("drain_timeout", 32'(m_valid), 32'h0);
        m_ready = 1'b0;
    endtask

    initial begin
        // Reset and idle
        repeat (3) tick();
        checkVal("rst_level", 32'(level), 32'h0);
        checkVal("rst_m_valid", 32'(m_valid), 32'h0);
        checkVal("rst_m_data", 32'(m_data), 32'h0);
        rst = 1'b1;
        repeat (10) tick();
        checkVal("idle_level", 32'(level), 32'h0);
        checkVal("idle_acc", 32'(acc_cnt), 32'h0);
        checkVal("idle_ovf", 32'(overflow), 32'h0);

        // Single pass-through
        m_ready = 1'b1;
        pushByte(8'h5A);
        checkVal("pt_valid", 32'(m_valid), 32'h1);
        checkVal("pt_data", 32'(m_data), 32'h5A);
        tick();
        checkVal("pt_level", 32'(level), 32'h0);
        checkVal("pt_acc", 32'(acc_cnt), 32'h1);
        checkVal("pt_sum", 32'(checksum), 32'h5A);
        m_ready = 1'b0;

        // Fill and overflow
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        for (int i = 1; i <= 10; i++) pushByte(8'(i));
        checkVal("fill_level", 32'(level), 32'h8);
        checkVal("fill_ovf", 32'(overflow), 32'h1);
        checkVal("fill_drop", 32'(drop_cnt), 32'h2);
        drainAll();
        checkVal("fill_sum", 32'(checksum), 32'd36);
        checkVal("fill_acc", 32'(acc_cnt), 32'd8);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 8; i++) pushByte(8'(i));
        m_ready = 1'b1;
        checkVal("fp_head", 32'(m_data), 32'h1);
        pushByte(8'hAA);
        m_ready = 1'b0;
        checkVal("fp_level", 32'(level), 32'h8);
        checkVal("fp_drop", 32'(drop_cnt), 32'h2);
        drainAll();

        // Drop counter saturation
        for (int i = 0; i < 8; i++) pushByte(8'(i + 16));
        for (int i = 0; i < 260; i++) pushByte(8'h33);
        checkVal("sat_drop", 32'(drop_cnt), 32'd255);
        drainAll();

        // Pointer and checksum wrap
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        m_ready = 1'b1;
        res_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            res_data = (i % 50 == 0) ? 8'(i) : 8'hFF;
            tick();
        end
        res_valid = 1'b0;
        res_data  = 8'h00;
        tick();
        checkVal("wrap_acc", 32'(acc_cnt), 32'd300);
        checkVal("wrap_drop", 32'(drop_cnt), 32'h0);
        m_ready = 1'b0;
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        m_ready = 1'b1;
        res_valid = 1'b1;
        res_data  = 8'hFF;
        repeat (300) tick();
        res_valid = 1'b0;
        res_data  = 8'h00;
        tick();
        checkVal("ff_acc", 32'(acc_cnt), 32'd300);
        checkVal("ff_sum", 32'(checksum), 32'hD4);
        m_ready = 1'b0;

        // clr_stats collision with a push
        clr_stats = 1'b1;
        pushByte(8'h07);
        clr_stats = 1'b0;
        checkVal("clr_acc", 32'(acc_cnt), 32'h0);
        checkVal("clr_sum", 32'(checksum), 32'h0);
        checkVal("clr_level", 32'(level), 32'h1);
        drainAll();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) pushByte(8'(i + 100));
        checkVal("pre_rst_level", 32'(level), 32'h5);
        rst = 1'b0;
        #1;
        checkVal("async_level", 32'(level), 32'h0);
        checkVal("async_valid", 32'(m_valid), 32'h0);
        tick();
        rst = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
